fifo: RTL and testbench

- Elastic DTI buffer of parameterised depth.
- Placed on individual output branches of the broadcast stage, so one slow consumer does not stall the shared input or its sibling branches.
- Also usable as a general decoupling stage between any DTI producer and consumer.
- Full throughput: one transfer in and one out per cycle.

---
 rtl/dti_pkg.sv | 12 +
 rtl/dti_if.sv | 13 +
 rtl/fifo_mem.sv | 25 ++
 rtl/fifo.sv | 88 ++++++++
 tb/tb_fifo.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dti_pkg.sv
// Shared DTI helpers: default stream width, minimum buffer depth and pointer sizing.
package dti_pkg;

    localparam int DTI_DEFAULT_WIDTH = 16;
    localparam int DTI_MIN_DEPTH     = 2;

    // One extra MSB beyond the address bits tells a full buffer apart from an empty one.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dti_if.sv
// DTI valid/ready stream bundle with producer and consumer views.
interface dti #(
    parameter int WIDTH = dti_pkg::DTI_DEFAULT_WIDTH
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);

endinterface

// File: rtl/fifo_mem.sv
// Unreset simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo.sv
// Elastic DTI buffer; define FIFO_LEVEL_EN to expose the occupancy port `level`.
module fifo
    import dti_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DTI_DEFAULT_WIDTH
) (
    input logic  clk,
    input logic  rst,
    dti.consumer din,
    dti.producer dout
`ifdef FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = ptrWidth(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    if (DEPTH < DTI_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("fifo: DEPTH must be a power of two and at least 2");
    end

    ptr_t wrPtr_q;
    ptr_t wrPtr_d;
    ptr_t rdPtr_q;
    ptr_t rdPtr_d;
    logic readyEn_q;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[PTR_W-1] != rdPtr_q[PTR_W-1]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // readyEn_q holds ready low through reset and rises on the first edge after release.
    assign din.ready  = readyEn_q & ~full;
    assign dout.valid = ~empty;

    assign push = din.valid & readyEn_q & ~full;
    assign pop  = dout.ready & ~empty;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push) begin
            wrPtr_d = wrPtr_q + ptr_t'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            readyEn_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            readyEn_q <= 1'b1;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) uMem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wrPtr_q[AW-1:0]),
        .wdata_i (din.data),
        .raddr_i (rdPtr_q[AW-1:0]),
        .rdata_o (dout.data)
    );

`ifdef FIFO_LEVEL_EN
    assign level = wrPtr_q - rdPtr_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Randomised self-checking bench for fifo against a queue-based occupancy model.
module tb_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dti #(.WIDTH(WIDTH)) inIf ();
    dti #(.WIDTH(WIDTH)) outIf ();

`ifdef FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (inIf),
        .dout (outIf)
`ifdef FIFO_LEVEL_EN
        ,
        .level (level)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model[$];
    bit               modelLive = 0;

    function automatic bit modelReady();
        return modelLive && (model.size() < DEPTH);
    endfunction

    function automatic bit modelValid();
        return model.size() > 0;
    endfunction

    // Advance one clock: handshakes are decided by the model, then the queue is updated.
    task automatic tick();
        bit               doPush;
        bit               doPop;
        logic [WIDTH-1:0] pushData;
        doPush   = inIf.valid && modelReady();
        doPop    = outIf.ready && modelValid();
        pushData = inIf.data;
        @(posedge clk);
        if (!rst) begin
            model.delete();
            modelLive = 0;
        end else begin
            if (doPop) void'(model.pop_front());
            if (doPush) model.push_back(pushData);
            modelLive = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        inIf.valid  = 1'b0;
        inIf.data   = '0;
        outIf.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outIf.valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cyc %0d got %b want 0", i, outIf.valid);
            end
            checks++;
            if (inIf.ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ready cyc %0d got %b want 0", i, inIf.ready);
            end
        end
        rst = 1'b1;
        checks++;
        if (inIf.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_ready_early got %b want 0", inIf.ready);
        end
        tick();
        checks++;
        if (inIf.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_ready got %b want 1", inIf.ready);
        end
        checks++;
        if (outIf.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_valid got %b want 0", outIf.valid);
        end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] words [5];
        int               idx;
        bit               acc;
        words[0] = 16'h11; words[1] = 16'h22; words[2] = 16'h33;
        words[3] = 16'h44; words[4] = 16'h55;
        idx = 0;
        outIf.ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            inIf.valid = 1'b1;
            inIf.data  = words[idx];
            checks++;
            if (inIf.ready !== modelReady()) begin
                errors++;
                $display("[TB] FAIL fill_ready cyc %0d got %b want %b", cyc, inIf.ready, modelReady());
            end
            acc = modelReady();
            tick();
            if (acc) idx++;
        end
        checks++;
        if (inIf.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full_ready got %b want 0", inIf.ready);
        end
        checks++;
        if (outIf.valid !== 1'b1 || outIf.data !== 16'h11) begin
            errors++;
            $display("[TB] FAIL fill_head got %b/%h want 1/0011", outIf.valid, outIf.data);
        end
`ifdef FIFO_LEVEL_EN
        checks++;
        if (level !== 3'(DEPTH)) begin
            errors++;
            $display("[TB] FAIL fill_level got %0d want %0d", level, DEPTH);
        end
`endif
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] expect_ [5];
        bit               acc;
        expect_[0] = 16'h11; expect_[1] = 16'h22; expect_[2] = 16'h33;
        expect_[3] = 16'h44; expect_[4] = 16'h55;
        outIf.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (outIf.valid !== 1'b1 || outIf.data !== expect_[k]) begin
                errors++;
                $display("[TB] FAIL drain_word %0d got %b/%h want 1/%h", k, outIf.valid, outIf.data, expect_[k]);
            end
            if (k == 1) begin
                checks++;
                if (inIf.ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL drain_ready_rise got %b want 1", inIf.ready);
                end
            end
            acc = inIf.valid && modelReady();
            tick();
            if (acc) inIf.valid = 1'b0;
        end
        checks++;
        if (outIf.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_empty got %b want 0", outIf.valid);
        end
    endtask

    task automatic test_stream();
        int  sent;
        bit  acc;
        sent = 0;
        outIf.ready = 1'b1;
        for (int cyc = 0; cyc < 103; cyc++) begin
            inIf.valid = (sent < 100);
            inIf.data  = WIDTH'(sent);
            if (cyc >= 1 && cyc <= 100) begin
                checks++;
                if (outIf.valid !== 1'b1 || outIf.data !== WIDTH'(cyc - 1)) begin
                    errors++;
                    $display("[TB] FAIL stream_out cyc %0d got %b/%h want 1/%h", cyc, outIf.valid, outIf.data, WIDTH'(cyc - 1));
                end
`ifdef FIFO_LEVEL_EN
                checks++;
                if (level !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL stream_level cyc %0d got %0d want 1", cyc, level);
                end
`endif
            end else begin
                checks++;
                if (outIf.valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_idle cyc %0d got %b want 0", cyc, outIf.valid);
                end
            end
            acc = inIf.valid && modelReady();
            tick();
            if (acc) sent++;
        end
        inIf.valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int  sent;
        int  received;
        int  cyc;
        bit  acc;
        sent     = 0;
        received = 0;
        cyc      = 0;
        inIf.valid = 1'b0;
        while (received < 1000 && cyc < 20000) begin
            if (!inIf.valid && sent < 1000) begin
                inIf.valid = ($urandom_range(0, 3) != 0);
                inIf.data  = WIDTH'($urandom);
            end
            outIf.ready = $urandom_range(0, 1) == 1;
            checks++;
            if (inIf.ready !== modelReady()) begin
                errors++;
                $display("[TB] FAIL bp_ready cyc %0d got %b want %b", cyc, inIf.ready, modelReady());
            end
            checks++;
            if (outIf.valid !== modelValid()) begin
                errors++;
                $display("[TB] FAIL bp_valid cyc %0d got %b want %b", cyc, outIf.valid, modelValid());
            end
            if (modelValid()) begin
                checks++;
                if (outIf.data !== model[0]) begin
                    errors++;
                    $display("[TB] FAIL bp_data cyc %0d got %h want %h", cyc, outIf.data, model[0]);
                end
            end
            acc = inIf.valid && modelReady();
            if (outIf.ready && modelValid()) received++;
            tick();
            if (acc) begin
                sent++;
                inIf.valid = 1'b0;
            end
            cyc++;
        end
        inIf.valid = 1'b0;
        checks++;
        if (received != 1000) begin
            errors++;
            $display("[TB] FAIL bp_timeout got %0d words want 1000", received);
        end
    endtask

    task automatic test_reset_mid();
        outIf.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inIf.valid = 1'b1;
            inIf.data  = WIDTH'($urandom);
            tick();
        end
        inIf.valid = 1'b0;
        checks++;
        if (outIf.valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_prefill got %b want 1", outIf.valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outIf.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_valid got %b want 0", outIf.valid);
        end
        checks++;
        if (inIf.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_ready got %b want 0", inIf.ready);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        inIf.valid = 1'b1;
        inIf.data  = 16'hAA;
        tick();
        inIf.valid  = 1'b0;
        outIf.ready = 1'b1;
        checks++;
        if (outIf.valid !== 1'b1 || outIf.data !== 16'hAA) begin
            errors++;
            $display("[TB] FAIL mid_first_word got %b/%h want 1/00aa", outIf.valid, outIf.data);
        end
        tick();
        checks++;
        if (outIf.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after_pop got %b want 0", outIf.valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
